// File: rtl/alu_seq_pkg.sv
// Purpose: shared types and constants for the sequential accumulator ALU (alu_seq).
// Latency: n/a, declarations only.
// Backpressure: n/a. Optional multiplier is enabled by defining ALU_SEQ_MUL_EN.
package alu_seq_pkg;

  localparam int W_DEFAULT  = 8;
  localparam int MW_DEFAULT = 4;

  // Operation encoding on the low four bits of the mode field.
  typedef enum logic [3:0] {
    MODE_ADD  = 4'd0,
    MODE_ASL  = 4'd1,
    MODE_XNOR = 4'd2,
    MODE_HALF = 4'd3,
    MODE_LDA  = 4'd4,
    MODE_STA  = 4'd5,
    MODE_NEG  = 4'd6,
    MODE_SUB  = 4'd7,
    MODE_MUL  = 4'd8
  } mode_e;

  // Any low-nibble value at or above this completes as an illegal op.
  localparam logic [3:0] MODE_ILLEGAL_MIN = 4'd9;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Purpose: control-unit <-> ALU bundle (start/mode/operands in, status/result out).
// Latency: n/a, wiring only.
// Backpressure: start is only taken while busy is low; master must re-issue otherwise.
interface alu_seq_if
  import alu_seq_pkg::*;
#(
  parameter int W  = W_DEFAULT,
  parameter int MW = MW_DEFAULT
) ();

  logic          start;
  logic [MW-1:0] mode;
  logic [W-1:0]  ac;
  logic [W-1:0]  dr;
  logic          busy;
  logic          done;
  logic          illegal;
  logic          e;
  logic [W-1:0]  result;

  modport master (
    output start, mode, ac, dr,
    input  busy, done, illegal, e, result
  );

  modport slave (
    input  start, mode, ac, dr,
    output busy, done, illegal, e, result
  );

endinterface

// File: rtl/alu_seq_mul.sv
// Purpose: unsigned iterative shift-add multiplier, one partial product per cycle.
// Latency: W cycles after go; done/prod are combinational during the last step.
// Backpressure: go is only legal while busy is low; the owner gates it.
module alu_seq_mul #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] prod
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  logic           r_busy;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_a;
  logic [W-1:0]   r_b;
  logic [2*W-1:0] w_acc_nxt;

  // Add the shifted multiplicand when the current multiplier bit is set.
  assign w_acc_nxt = r_acc + (r_b[0] ? r_a : '0);

  // prod is the accumulator after this cycle's step, so the owner can
  // capture the final product on the same edge that ends the run.
  assign busy = r_busy;
  assign done = r_busy && (r_cnt == CW'(W - 1));
  assign prod = w_acc_nxt;

  // Load operands on go, then shift-add once per cycle until W steps are done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_a    <= '0;
      r_b    <= '0;
    end else if (go) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_a    <= {{W{1'b0}}, a};
      r_b    <= b;
    end else if (r_busy) begin
      r_acc <= w_acc_nxt;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt + CW'(1);
      if (done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Purpose: clocked accumulator ALU (ADD/ASL/XNOR/HALF/LDA/STA/NEG/SUB, MUL when ALU_SEQ_MUL_EN).
// Latency: 1 cycle accept-to-done for single-cycle and illegal ops, W+1 for MUL.
// Backpressure: start ignored while busy (no queueing); result/e hold until the next completion.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W  = W_DEFAULT,
  parameter int MW = MW_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  state_e       r_state;
  state_e       w_state_nxt;
  logic [W-1:0] r_result;
  logic [W-1:0] w_result_nxt;
  logic         r_e;
  logic         w_e_nxt;
  logic         r_done;
  logic         w_done_nxt;
  logic         r_illegal;
  logic         w_illegal_nxt;
  logic [W:0]   w_sum;
  logic [3:0]   w_mode_lo;
  logic         w_mode_hi_nz;
  logic         w_mode_bad;

  // Only the low nibble carries an opcode; anything set above it is illegal.
  assign w_mode_lo    = bus.mode[3:0];
  assign w_mode_hi_nz = |(bus.mode >> 4);
  assign w_mode_bad   = w_mode_hi_nz || (w_mode_lo >= MODE_ILLEGAL_MIN);

`ifdef ALU_SEQ_MUL_EN
  logic           w_mul_go;
  logic           w_mul_busy;
  logic           w_mul_done;
  logic [2*W-1:0] w_mul_prod;

  alu_seq_mul #(
    .W(W)
  ) u_mul (
    .clk  (clk),
    .rst  (rst),
    .go   (w_mul_go),
    .a    (bus.ac),
    .b    (bus.dr),
    .busy (w_mul_busy),
    .done (w_mul_done),
    .prod (w_mul_prod)
  );

  assign bus.busy = w_mul_busy;
`else
  assign bus.busy = 1'b0;
`endif

  assign bus.done    = r_done;
  assign bus.illegal = r_illegal;
  assign bus.e       = r_e;
  assign bus.result  = r_result;

  // Next-state and next-output logic: accept in IDLE, finish MUL on the last step.
  always_comb begin
    w_state_nxt   = r_state;
    w_result_nxt  = r_result;
    w_e_nxt       = r_e;
    w_done_nxt    = 1'b0;
    w_illegal_nxt = 1'b0;
    w_sum         = '0;
`ifdef ALU_SEQ_MUL_EN
    w_mul_go      = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_mode_bad) begin
            w_done_nxt    = 1'b1;
            w_illegal_nxt = 1'b1;
          end else begin
            w_done_nxt = 1'b1;
            case (w_mode_lo)
              MODE_ADD: begin
                w_sum        = {1'b0, bus.ac} + {1'b0, bus.dr};
                w_result_nxt = w_sum[W-1:0];
                w_e_nxt      = w_sum[W];
              end
              MODE_ASL: begin
                w_result_nxt = {bus.dr[W-2:0], 1'b0};
                w_e_nxt      = bus.dr[W-1];
              end
              MODE_XNOR: begin
                w_result_nxt = ~(bus.ac ^ bus.dr);
                w_e_nxt      = 1'b0;
              end
              MODE_HALF: begin
                w_result_nxt = {1'b0, bus.dr[W-1:1]};
                w_e_nxt      = bus.dr[0];
              end
              MODE_LDA: begin
                w_result_nxt = bus.dr;
                w_e_nxt      = 1'b0;
              end
              MODE_STA: begin
                w_result_nxt = bus.ac;
                w_e_nxt      = 1'b0;
              end
              MODE_NEG: begin
                // Carry out of ~dr + 1 is set exactly when dr is zero.
                w_sum        = {1'b0, ~bus.dr} + {{W{1'b0}}, 1'b1};
                w_result_nxt = w_sum[W-1:0];
                w_e_nxt      = w_sum[W];
              end
              MODE_SUB: begin
                // e=1 means no borrow (ac >= dr).
                w_sum        = {1'b0, bus.ac} + {1'b0, ~bus.dr} + {{W{1'b0}}, 1'b1};
                w_result_nxt = w_sum[W-1:0];
                w_e_nxt      = w_sum[W];
              end
`ifdef ALU_SEQ_MUL_EN
              MODE_MUL: begin
                w_done_nxt  = 1'b0;
                w_mul_go    = 1'b1;
                w_state_nxt = S_MUL;
              end
`endif
              default: begin
                w_illegal_nxt = 1'b1;
              end
            endcase
          end
        end
      end
      S_MUL: begin
`ifdef ALU_SEQ_MUL_EN
        if (w_mul_done) begin
          w_result_nxt = w_mul_prod[W-1:0];
          w_e_nxt      = |w_mul_prod[2*W-1:W];
          w_done_nxt   = 1'b1;
          w_state_nxt  = S_IDLE;
        end
`else
        w_state_nxt = S_IDLE;
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset also aborts an in-flight multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_result  <= '0;
      r_e       <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_result  <= w_result_nxt;
      r_e       <= w_e_nxt;
      r_done    <= w_done_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Purpose: bench for alu_seq at W=8 and W=16 driven by one shared stimulus stream.
// Latency: reference model tracks 1-cycle ops and W-step MUL (when ALU_SEQ_MUL_EN).
// Backpressure: model drops starts that arrive while an op is still running.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        s_rst;
  logic        s_start;
  logic [3:0]  s_mode;
  logic [15:0] s_ac;
  logic [15:0] s_dr;

  int total = 0;
  int bad   = 0;

  alu_seq_if #(.W(8),  .MW(4)) if8  ();
  alu_seq_if #(.W(16), .MW(4)) if16 ();

  assign if8.start  = s_start;
  assign if8.mode   = s_mode;
  assign if8.ac     = s_ac[7:0];
  assign if8.dr     = s_dr[7:0];
  assign if16.start = s_start;
  assign if16.mode  = s_mode;
  assign if16.ac    = s_ac;
  assign if16.dr    = s_dr;

  alu_seq #(.W(8), .MW(4)) u_dut8 (
    .clk (clk),
    .rst (s_rst),
    .bus (if8)
  );

  alu_seq #(.W(16), .MW(4)) u_dut16 (
    .clk (clk),
    .rst (s_rst),
    .bus (if16)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the operation table, on plain integers.
  function automatic void calc(input int w, input int md, input longint a, input longint b,
                               output bit ill, output bit is_mul, output longint r, output bit e);
    longint m;
    m      = longint'(1) << w;
    ill    = 1'b0;
    is_mul = 1'b0;
    r      = 0;
    e      = 1'b0;
    case (md)
      0: begin r = (a + b) % m;     e = ((a + b) >= m); end
      1: begin r = (b * 2) % m;     e = (b >= m / 2);   end
      2: begin r = (m - 1) - (a ^ b);                    end
      3: begin r = b / 2;           e = ((b % 2) == 1); end
      4: begin r = b;                                    end
      5: begin r = a;                                    end
      6: begin r = (m - b) % m;     e = (b == 0);       end
      7: begin r = (a - b + m) % m; e = (a >= b);       end
`ifdef ALU_SEQ_MUL_EN
      8: begin is_mul = 1'b1; r = (a * b) % m; e = ((a * b) >= m); end
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  int     WS [2] = '{8, 16};
  bit     m_vld = 1'b0;
  int     m_left [2];
  longint m_res [2];
  longint p_res [2];
  bit     m_e [2];
  bit     p_e [2];
  bit     m_done [2];
  bit     m_ill [2];
  bit     md_ill;
  bit     md_mul;
  longint md_r;
  bit     md_e;
  longint md_msk;

  // Model: advance both widths by one clock using the stimulus seen at this edge.
  always @(posedge clk) begin
    if (s_rst) begin
      m_vld = 1'b1;
      for (int d = 0; d < 2; d++) begin
        m_left[d] = 0; m_res[d] = 0; m_e[d] = 1'b0; m_done[d] = 1'b0; m_ill[d] = 1'b0;
      end
    end else if (m_vld) begin
      for (int d = 0; d < 2; d++) begin
        m_done[d] = 1'b0;
        m_ill[d]  = 1'b0;
        if (m_left[d] > 0) begin
          m_left[d]--;
          if (m_left[d] == 0) begin
            m_res[d] = p_res[d]; m_e[d] = p_e[d]; m_done[d] = 1'b1;
          end
        end else if (s_start) begin
          md_msk = (longint'(1) << WS[d]) - 1;
          calc(WS[d], int'(s_mode), longint'(s_ac) & md_msk, longint'(s_dr) & md_msk,
               md_ill, md_mul, md_r, md_e);
          if (md_ill) begin
            m_done[d] = 1'b1; m_ill[d] = 1'b1;
          end else if (md_mul) begin
            m_left[d] = WS[d]; p_res[d] = md_r; p_e[d] = md_e;
          end else begin
            m_res[d] = md_r; m_e[d] = md_e; m_done[d] = 1'b1;
          end
        end
      end
    end
  end

  function automatic logic [63:0] exp_vec(input int d);
    exp_vec = {44'd0, (m_left[d] > 0), m_done[d], m_ill[d], m_e[d], 16'(m_res[d])};
  endfunction

  // Compare every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_vld) begin
      chk("cycle_w8",  {44'd0, if8.busy, if8.done, if8.illegal, if8.e, 8'd0, if8.result}, exp_vec(0));
      chk("cycle_w16", {44'd0, if16.busy, if16.done, if16.illegal, if16.e, if16.result}, exp_vec(1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int md, input int a, input int b);
    s_start = 1'b1;
    s_mode  = 4'(md);
    s_ac    = 16'(a);
    s_dr    = 16'(b);
    tick();
    s_start = 1'b0;
  endtask

  bit     pin_ill;
  bit     pin_mul;
  longint pin_r;
  bit     pin_e;

  initial begin
    s_rst = 1'b1; s_start = 1'b0; s_mode = '0; s_ac = '0; s_dr = '0;

    // Pin the model against hand-worked values.
    calc(8, 7, 5, 7, pin_ill, pin_mul, pin_r, pin_e);
    chk("model_sub", {pin_ill, pin_e, 16'(pin_r)}, {1'b0, 1'b0, 16'h00FE});
    calc(16, 0, 'hFFFF, 1, pin_ill, pin_mul, pin_r, pin_e);
    chk("model_add16", {pin_ill, pin_e, 16'(pin_r)}, {1'b0, 1'b1, 16'h0000});
    calc(8, 6, 0, 0, pin_ill, pin_mul, pin_r, pin_e);
    chk("model_neg0", {pin_ill, pin_e, 16'(pin_r)}, {1'b0, 1'b1, 16'h0000});

    tick(); tick();
    s_rst = 1'b0;
    chk("reset_state", {if8.busy, if8.done, if8.illegal, if8.e, if8.result}, 12'h000);

    issue(0, 'hF0, 'h20);
    chk("add_res",  if8.result, 'h10);
    chk("add_flag", {if8.done, if8.illegal, if8.e}, 3'b101);

    issue(7, 'h05, 'h07);
    chk("sub_res", if8.result, 'hFE);
    chk("sub_e",   if8.e, 0);
    issue(6, 0, 'h00);
    chk("neg_res", if8.result, 'h00);
    chk("neg_e",   if8.e, 1);

    issue(1, 0, 'h81);
    chk("asl", {if8.e, if8.result}, 9'h102);
    issue(3, 0, 'h03);
    chk("half", {if8.e, if8.result}, 9'h101);
    issue(2, 'hAA, 'h0F);
    chk("xnor", {if8.e, if8.result}, 9'h05A);

    issue(12, 'h33, 'h44);
    chk("illegal_pulse", {if8.done, if8.illegal, if8.e, if8.result}, 11'h65A);
    tick();
    chk("illegal_after", {if8.done, if8.illegal, if8.result}, 10'h05A);

    issue(8, 'h21, 'h03);
`ifdef ALU_SEQ_MUL_EN
    repeat (20) tick();
`else
    chk("mode8_illegal", {if8.done, if8.illegal, if8.busy}, 3'b110);
`endif

    issue(0, 'hFFFF, 'h0001);
    chk("add16", {if16.e, if16.result}, 17'h10000);

`ifdef ALU_SEQ_MUL_EN
    repeat (2) tick();
    issue(8, 'h10, 'h11);
    for (int k = 1; k <= 8; k++) begin
      chk("mul_busy", {if8.busy, if8.done}, 2'b10);
      if (k == 4) begin
        s_start = 1'b1; s_mode = 4'd0;
      end
      tick();
      s_start = 1'b0;
    end
    chk("mul_done", {if8.busy, if8.done, if8.illegal, if8.e, if8.result}, 12'h51_0);

    repeat (10) tick();
    issue(8, 'h77, 'h55);
    repeat (3) tick();
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    chk("mul_abort", {if8.busy, if8.done, if8.e, if8.result}, 11'h000);
    tick();
    chk("mul_abort_nodone", {if8.busy, if8.done}, 2'b00);
`endif

    // Randomised traffic with occasional resets; the per-cycle compare does the checking.
    repeat (1500) begin
      s_rst   = ($urandom_range(0, 99) == 0);
      s_start = 1'($urandom_range(0, 1));
      s_mode  = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
      s_ac    = 16'($urandom);
      s_dr    = 16'($urandom);
      tick();
    end
    s_rst = 1'b0;
    s_start = 1'b0;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Clocked, parametrised successor to the 8-bit combinational-trigger accumulator ALU.
- Width is generic and the op set is extended with SUB and an optional iterative MUL.
- Uses a start/done handshake with a busy indication, plus an illegal-opcode flag.
- Sits between the control unit (mode, start) and the AC/DR registers of the CPU datapath. Result and E are registered and hold until the next completed operation.

Parameters:
- W, 8, operand/result width in bits (W >= 2).
- MW, 4, mode field width (fixed encoding needs >= 4).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- mode  in  MW  operation select, sampled at accept.
- ac  in  W  accumulator operand, sampled at accept.
- dr  in  W  data-register operand, sampled at accept.
- busy  out  1  high while a multi-cycle op is in progress.
- done  out  1  one-cycle pulse: result/E/illegal valid and updated.
- illegal  out  1  high during the done cycle if mode was unsupported.
- e  out  1  carry/extension flag.
- result  out  W  operation result.

Behaviour:
- Reset:
  - Applies on any clk edge with rst=1, including mid-MUL (aborts; partial product discarded).
  - Outputs after reset: state=IDLE, busy=0, done=0, illegal=0, e=0, result=0.
- FSM states: IDLE, MUL.
  - IDLE + start: latch mode/ac/dr.
  - Single-cycle op: stay IDLE. result/e written at that edge; done=1 in the following cycle (latency 1).
  - MUL: go to MUL with counter=0.
  - MUL: one shift-add step per cycle. After W steps, write result/e, return to IDLE, done=1 next cycle. Latency is W+1 cycles from the accept edge.
- Back-to-back ops: done cycle has busy=0, so start in the done cycle is accepted.
- start while busy=1 is ignored (no queueing). ac/dr/mode changes while busy have no effect.
- Mode encoding (sums at W+1 bits, e = bit W unless stated):
  - 0 ADD: {e,result} = ac + dr.
  - 1 ASL: result = dr << 1 (LSB 0); e = dr[W-1].
  - 2 XNOR: result = ~(ac ^ dr); e = 0.
  - 3 HALF: result = dr >> 1 logical (divide by 2, floor); e = dr[0].
  - 4 LDA: result = dr; e = 0.
  - 5 STA: result = ac (value driven to memory path); e = 0.
  - 6 NEG: result = ~dr + 1 mod 2^W; e = (dr == 0) (carry out).
  - 7 SUB: {e,result} = ac + ~dr + 1; e = 1 means no borrow.
  - 8 MUL: see Optional Feature.
  - 9..15: illegal (see below).
- Illegal mode: completes with latency 1, done=1 and illegal=1; result and e hold previous values.
- done and illegal are single-cycle pulses, never high outside the done cycle.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: mode 8 = unsigned iterative shift-add multiply, W steps.
  - result = low W bits of ac*dr; e = OR of high W bits (overflow).
  - busy=1 from the cycle after accept through the last step.
- Undefined: no multiplier logic. Mode 8 is treated as illegal (latency 1, illegal=1, outputs hold); busy is tied 0.

Decomposition:
- Package alu_seq_pkg: mode enum (ADD, ASL, XNOR, HALF, LDA, STA, NEG, SUB, MUL), FSM state enum, default W, MODE_ILLEGAL_MIN = 9.
- Sub-module alu_seq_mul, instantiated only under ALU_SEQ_MUL_EN.
  - Ports: clk, rst, go, a, b, busy, done, prod[2W-1:0].
  - Implements the iterative datapath and step counter.

Test Plan:
- Reset, then ADD ac=0xF0 dr=0x20 -> done after 1 cycle; result=0x10, e=1, illegal=0.
- SUB ac=0x05 dr=0x07 -> result=0xFE, e=0. Immediately on the done cycle, start NEG dr=0x00 -> accepted; next cycle result=0x00, e=1.
- ASL dr=0x81 -> result=0x02, e=1. HALF dr=0x03 -> result=0x01, e=1. XNOR ac=0xAA dr=0x0F -> result=0x5A, e=0.
- mode=12 after a prior result 0x5A -> done=1, illegal=1, result stays 0x5A; the following cycle illegal=0, done=0.
- (MUL_EN) MUL ac=0x10 dr=0x11 -> busy=1 for 8 cycles, done at cycle 9: result=0x10, e=1. A start pulse issued mid-operation is ignored.
- (MUL_EN) MUL in progress, rst=1 at step 4 -> next cycle busy=0, result=0, e=0, no done pulse. Repeat at W=16: ADD 0xFFFF+0x0001 -> result=0x0000, e=1.
